// File: rtl/fuzzy_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// fuzzy_sweep_ctrl
//
// On-chip surface-capture sequencer for the Fuzzy_1 type-2 inference core.
// Walks a 2-D grid of raw indices (i outer, j inner) in increments of STEP up
// to, but not including, END. For each point it drives the clamped indices onto
// Entrada_01/02 and waits SETTLE cycles. It then captures saida_defuzzy and
// offers the result downstream over a valid/ready handshake.
//
// Ports
//   clk_0          system clock, all state on the rising edge
//   Srst           asynchronous, active-high reset
//   start          begin a sweep (sampled only while idle)
//   abort          cancel the sweep in progress (wins over start)
//   busy           high from the cycle after start acceptance through DONE
//   done           one-cycle pulse after the final result is accepted
//   EN_REGRAS      rule enable to Fuzzy_1, mirrors busy
//   Entrada_01/02  clamped outer / inner axis values to Fuzzy_1
//   saida_defuzzy  defuzzified output from Fuzzy_1
//   res_valid      captured result available
//   res_ready      consumer accepts the result
//   res_data       captured saida_defuzzy
//   res_i/res_j    raw outer / inner index of the captured point
//   point_cnt      results accepted since the last start
// -----------------------------------------------------------------------------
module fuzzy_sweep_ctrl #(
  parameter int STEP     = 1,
  parameter int END      = 255,
  parameter int CLAMP_LO = 1,
  parameter int CLAMP_HI = 254,
  parameter int SETTLE   = 7
) (
  input  logic        clk_0,
  input  logic        Srst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        EN_REGRAS,
  output logic [7:0]  Entrada_01,
  output logic [7:0]  Entrada_02,
  input  logic [7:0]  saida_defuzzy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [8:0]  res_i,
  output logic [8:0]  res_j,
  output logic [16:0] point_cnt
);

  // The counter only has to hold SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // The index arithmetic is one bit wider than the indices, so END=256 and
  // i+STEP compare correctly without wrapping.
  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [9:0] END_W  = 10'(END);
  localparam logic [8:0] LO_W   = 9'(CLAMP_LO);
  localparam logic [8:0] HI_W   = 9'(CLAMP_HI);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [8:0]         r_i;
  logic [8:0]         r_j;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_en;
  logic [7:0]         r_e1;
  logic [7:0]         r_e2;
  logic               r_valid;
  logic [7:0]         r_data;
  logic [8:0]         r_res_i;
  logic [8:0]         r_res_j;
  logic [16:0]        r_point_cnt;

  logic [9:0]         w_i_next;
  logic [9:0]         w_j_next;

  assign w_i_next = {1'b0, r_i} + STEP_W;
  assign w_j_next = {1'b0, r_j} + STEP_W;

  // Saturate the raw index into the input range Fuzzy_1 is characterised for.
  function automatic logic [7:0] clamp8(input logic [8:0] raw);
    logic [8:0] v;
    v = raw;
    if (raw < LO_W)      v = LO_W;
    else if (raw > HI_W) v = HI_W;
    return v[7:0];
  endfunction

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples the pre-edge values, so the statement order here does not
  // change the behaviour.
  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_en        <= 1'b0;
      r_e1        <= 8'(CLAMP_LO);
      r_e2        <= 8'(CLAMP_LO);
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_res_i     <= '0;
      r_res_j     <= '0;
      r_point_cnt <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Cancel without a done pulse. Progress counters keep their value.
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_i         <= '0;
            r_j         <= '0;
            r_point_cnt <= '0;
            r_busy      <= 1'b1;
            r_en        <= 1'b1;
            r_state     <= S_APPLY;
          end
        end

        S_APPLY: begin
          r_e1    <= clamp8(r_i);
          r_e2    <= clamp8(r_j);
          r_cnt   <= CNT_W'(SETTLE - 1);
          r_state <= S_SETTLE;
        end

        // The capture lands exactly SETTLE edges after the Entrada update.
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_data  <= saida_defuzzy;
            r_res_i <= r_i;
            r_res_j <= r_j;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_HOLD: begin
          if (res_ready) begin
            r_valid     <= 1'b0;
            r_point_cnt <= r_point_cnt + 1'b1;
            if (w_j_next < END_W) begin
              r_j     <= w_j_next[8:0];
              r_state <= S_APPLY;
            end else if (w_i_next < END_W) begin
              r_j     <= '0;
              r_i     <= w_i_next[8:0];
              r_state <= S_APPLY;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign EN_REGRAS  = r_en;
  assign Entrada_01 = r_e1;
  assign Entrada_02 = r_e2;
  assign res_valid  = r_valid;
  assign res_data   = r_data;
  assign res_i      = r_res_i;
  assign res_j      = r_res_j;
  assign point_cnt  = r_point_cnt;

endmodule

// File: tb/tb_fuzzy_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fuzzy_sweep_ctrl
//
// Directed bench for fuzzy_sweep_ctrl. It uses two instances:
//   dut_a : END=4,   STEP=2,  SETTLE=3 (small 2x2 grid, abort, async reset)
//   dut_b : END=256, STEP=16, SETTLE=3 (16x16 grid with clamping at raw 0)
// In both instances Fuzzy_1 is replaced by saida = Entrada_01 ^ Entrada_02.
// Inputs are driven and outputs are sampled on the falling edge of clk_0.
// -----------------------------------------------------------------------------
module tb_fuzzy_sweep_ctrl;

  logic        clk_0 = 1'b0;
  logic        Srst  = 1'b1;

  logic        a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0;
  logic        a_busy, a_done, a_en, a_valid;
  logic [7:0]  a_e1, a_e2, a_saida, a_data;
  logic [8:0]  a_ri, a_rj;
  logic [16:0] a_pcnt;

  logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
  logic        b_busy, b_done, b_en, b_valid;
  logic [7:0]  b_e1, b_e2, b_saida, b_data;
  logic [8:0]  b_ri, b_rj;
  logic [16:0] b_pcnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected order for the 2x2 grid: (i,j) and saida = clamp(i)^clamp(j).
  logic [8:0] sg_i [4] = '{9'd0, 9'd0, 9'd2, 9'd2};
  logic [8:0] sg_j [4] = '{9'd0, 9'd2, 9'd0, 9'd2};
  logic [7:0] sg_d [4] = '{8'd0, 8'd3, 8'd3, 8'd0};

  assign a_saida = a_e1 ^ a_e2;
  assign b_saida = b_e1 ^ b_e2;

  always #5 clk_0 = ~clk_0;

  fuzzy_sweep_ctrl #(.STEP(2), .END(4), .CLAMP_LO(1), .CLAMP_HI(254), .SETTLE(3)) dut_a (
    .clk_0(clk_0), .Srst(Srst), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .EN_REGRAS(a_en),
    .Entrada_01(a_e1), .Entrada_02(a_e2), .saida_defuzzy(a_saida),
    .res_valid(a_valid), .res_ready(a_ready), .res_data(a_data),
    .res_i(a_ri), .res_j(a_rj), .point_cnt(a_pcnt)
  );

  fuzzy_sweep_ctrl #(.STEP(16), .END(256), .CLAMP_LO(1), .CLAMP_HI(254), .SETTLE(3)) dut_b (
    .clk_0(clk_0), .Srst(Srst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .EN_REGRAS(b_en),
    .Entrada_01(b_e1), .Entrada_02(b_e2), .saida_defuzzy(b_saida),
    .res_valid(b_valid), .res_ready(b_ready), .res_data(b_data),
    .res_i(b_ri), .res_j(b_rj), .point_cnt(b_pcnt)
  );

  // Reference clamp, written independently of the design.
  function automatic logic [7:0] clampm(input logic [8:0] raw);
    if (raw < 9'd1)   return 8'd1;
    if (raw > 9'd254) return 8'd254;
    return raw[7:0];
  endfunction

  task automatic test_reset();
    Srst = 1'b1;
    repeat (3) @(posedge clk_0);
    @(negedge clk_0);
    Srst = 1'b0;
    @(negedge clk_0);
    n_checks++;
    if ({a_busy, a_done, a_en, a_valid} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_flags: busy/done/en/valid got %b expected 0000", {a_busy, a_done, a_en, a_valid});
    end
    n_checks++;
    if ({a_data, a_ri, a_rj, a_pcnt} !== 43'd0) begin
      n_fails++;
      $display("FAIL reset_result: data=%0d i=%0d j=%0d cnt=%0d expected all 0", a_data, a_ri, a_rj, a_pcnt);
    end
    n_checks++;
    if ({a_e1, a_e2, b_e1, b_e2} !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
      n_fails++;
      $display("FAIL reset_entrada: a=%0d/%0d b=%0d/%0d expected 1/1", a_e1, a_e2, b_e1, b_e2);
    end
    n_checks++;
    if ({b_busy, b_done, b_en, b_valid, b_pcnt} !== 21'd0) begin
      n_fails++;
      $display("FAIL reset_b: busy/done/en/valid=%b cnt=%0d expected 0", {b_busy, b_done, b_en, b_valid}, b_pcnt);
    end
  endtask

  // Runs one full 2x2 sweep on dut_a. With bp set, the second result is held
  // off for 10 cycles and must stay stable for the whole stall.
  task automatic run_small(input bit bp, input string tag);
    int         npts, dones, last_chg, stall;
    bit         stalled, take;
    logic       pv;
    logic [7:0] pe1, pe2, sd, se1, se2;
    logic [8:0] si, sj;
    npts = 0; dones = 0; last_chg = -1; stall = 0; stalled = 0;
    sd = '0; se1 = '0; se2 = '0; si = '0; sj = '0;
    @(negedge clk_0);
    a_start = 1'b1;
    a_ready = 1'b1;
    pv = a_valid; pe1 = a_e1; pe2 = a_e2;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_0);
      take = 1'b0;
      if (k == 1) begin
        a_start = 1'b0;
        n_checks++;
        if ({a_busy, a_en} !== 2'b11) begin
          n_fails++;
          $display("FAIL %s_busy_en: got %b expected 11", tag, {a_busy, a_en});
        end
      end
      if (a_e1 !== pe1 || a_e2 !== pe2) last_chg = k;
      if (a_done === 1'b1) dones++;
      if (stall > 0) begin
        n_checks++;
        if ({a_valid, a_data, a_ri, a_rj, a_e1, a_e2} !== {1'b1, sd, si, sj, se1, se2}) begin
          n_fails++;
          $display("FAIL %s_stall_stable: v=%b d=%0d i=%0d j=%0d e=%0d/%0d expected 1 %0d %0d %0d %0d/%0d",
                   tag, a_valid, a_data, a_ri, a_rj, a_e1, a_e2, sd, si, sj, se1, se2);
        end
        stall--;
        if (stall == 0) begin
          a_ready = 1'b1;
          take = 1'b1;
        end
      end else if (a_valid === 1'b1) begin
        if (pv !== 1'b1) begin
          n_checks++;
          if ((npts == 0) ? (k != 5) : (k - last_chg != 3)) begin
            n_fails++;
            $display("FAIL %s_latency: point %0d valid at k=%0d, Entrada change at k=%0d, expected k=5 / change+3",
                     tag, npts, k, last_chg);
          end
        end
        if (bp && npts == 1 && !stalled) begin
          stalled = 1'b1;
          stall = 10;
          a_ready = 1'b0;
          sd = a_data; si = a_ri; sj = a_rj; se1 = a_e1; se2 = a_e2;
        end else begin
          take = 1'b1;
        end
      end
      if (take) begin
        n_checks++;
        if (npts >= 4) begin
          n_fails++;
          $display("FAIL %s_extra_point: point %0d (i=%0d j=%0d) expected only 4 points", tag, npts, a_ri, a_rj);
        end else if ({a_ri, a_rj, a_data} !== {sg_i[npts], sg_j[npts], sg_d[npts]}) begin
          n_fails++;
          $display("FAIL %s_point%0d: i=%0d j=%0d data=%0d expected i=%0d j=%0d data=%0d",
                   tag, npts, a_ri, a_rj, a_data, sg_i[npts], sg_j[npts], sg_d[npts]);
        end
        npts++;
      end
      pv = a_valid; pe1 = a_e1; pe2 = a_e2;
    end
    n_checks++;
    if (npts != 4 || dones != 1) begin
      n_fails++;
      $display("FAIL %s_count: points=%0d done_cycles=%0d expected 4 and 1", tag, npts, dones);
    end
    n_checks++;
    if (a_pcnt !== 17'd4) begin
      n_fails++;
      $display("FAIL %s_point_cnt: got %0d expected 4", tag, a_pcnt);
    end
    n_checks++;
    if ({a_busy, a_en, a_valid} !== 3'b000) begin
      n_fails++;
      $display("FAIL %s_idle_after: busy/en/valid got %b expected 000", tag, {a_busy, a_en, a_valid});
    end
  endtask

  task automatic test_small_grid();
    run_small(1'b0, "grid");
  endtask

  task automatic test_backpressure();
    run_small(1'b1, "bp");
  endtask

  task automatic test_clamp();
    int         npts, dones;
    logic [8:0] ei, ej;
    npts = 0; dones = 0; ei = '0; ej = '0;
    @(negedge clk_0);
    b_start = 1'b1;
    b_ready = 1'b1;
    for (int k = 1; k <= 1400; k++) begin
      @(negedge clk_0);
      if (k == 1) b_start = 1'b0;
      if (b_done === 1'b1) dones++;
      if (b_valid === 1'b1) begin
        n_checks++;
        if ({b_ri, b_rj, b_data} !== {ei, ej, clampm(ei) ^ clampm(ej)}) begin
          n_fails++;
          $display("FAIL clamp_point%0d: i=%0d j=%0d data=%0d expected i=%0d j=%0d data=%0d",
                   npts, b_ri, b_rj, b_data, ei, ej, clampm(ei) ^ clampm(ej));
        end
        if (npts == 0) begin
          n_checks++;
          if ({b_e1, b_e2} !== {8'd1, 8'd1}) begin
            n_fails++;
            $display("FAIL clamp_low: Entrada=%0d/%0d expected 1/1", b_e1, b_e2);
          end
        end
        if (ei == 9'd240 && ej == 9'd0) begin
          n_checks++;
          if (b_e1 !== 8'd240) begin
            n_fails++;
            $display("FAIL clamp_240: Entrada_01=%0d expected 240", b_e1);
          end
        end
        if (npts == 255) begin
          n_checks++;
          if ({b_ri, b_rj} !== {9'd240, 9'd240}) begin
            n_fails++;
            $display("FAIL clamp_last: i=%0d j=%0d expected 240/240", b_ri, b_rj);
          end
        end
        npts++;
        ej = ej + 9'd16;
        if (ej >= 9'd256) begin
          ej = '0;
          ei = ei + 9'd16;
        end
      end
    end
    n_checks++;
    if (npts != 256 || dones != 1 || b_pcnt !== 17'd256) begin
      n_fails++;
      $display("FAIL clamp_total: points=%0d done_cycles=%0d cnt=%0d expected 256 1 256", npts, dones, b_pcnt);
    end
  endtask

  task automatic test_abort();
    int  spurious;
    bit  found;
    spurious = 0;
    found = 1'b0;
    @(negedge clk_0);
    a_start = 1'b1;
    a_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_0);
      if (k == 1) a_start = 1'b0;
    end
    // Third point is settling: two results already accepted.
    n_checks++;
    if ({a_busy, a_valid, a_pcnt} !== {1'b1, 1'b0, 17'd2}) begin
      n_fails++;
      $display("FAIL abort_pre: busy=%b valid=%b cnt=%0d expected 1 0 2", a_busy, a_valid, a_pcnt);
    end
    a_abort = 1'b1;
    @(negedge clk_0);
    a_abort = 1'b0;
    n_checks++;
    if ({a_busy, a_en, a_valid, a_done, a_pcnt} !== {4'b0000, 17'd2}) begin
      n_fails++;
      $display("FAIL abort_now: busy/en/valid/done=%b cnt=%0d expected 0000 2",
               {a_busy, a_en, a_valid, a_done}, a_pcnt);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_0);
      if (a_done === 1'b1 || a_busy === 1'b1) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fails++;
      $display("FAIL abort_quiet: %0d cycles with busy or done after abort, expected 0", spurious);
    end
    // start and abort together while idle: abort wins.
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk_0);
    a_start = 1'b0;
    a_abort = 1'b0;
    n_checks++;
    if ({a_busy, a_pcnt} !== {1'b0, 17'd2}) begin
      n_fails++;
      $display("FAIL start_abort_idle: busy=%b cnt=%0d expected 0 2", a_busy, a_pcnt);
    end
    // A fresh start restarts from (0,0) with a cleared count.
    a_start = 1'b1;
    @(negedge clk_0);
    a_start = 1'b0;
    n_checks++;
    if ({a_busy, a_pcnt} !== {1'b1, 17'd0}) begin
      n_fails++;
      $display("FAIL restart: busy=%b cnt=%0d expected 1 0", a_busy, a_pcnt);
    end
    for (int k = 2; k <= 8 && !found; k++) begin
      @(negedge clk_0);
      if (a_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || {a_ri, a_rj, a_data} !== 26'd0) begin
      n_fails++;
      $display("FAIL restart_first: seen=%0d i=%0d j=%0d data=%0d expected seen=1 0 0 0", found, a_ri, a_rj, a_data);
    end
    repeat (30) @(negedge clk_0);
  endtask

  task automatic test_async_reset();
    @(negedge clk_0);
    a_start = 1'b1;
    a_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_0);
      case (k)
        1: a_start = 1'b0;
        3: a_start = 1'b1;
        4: a_start = 1'b0;
        5: begin
          n_checks++;
          if ({a_valid, a_ri, a_rj, a_pcnt} !== {1'b1, 9'd0, 9'd0, 17'd0}) begin
            n_fails++;
            $display("FAIL busy_start_p0: valid=%b i=%0d j=%0d cnt=%0d expected 1 0 0 0", a_valid, a_ri, a_rj, a_pcnt);
          end
          a_ready = 1'b1;
          a_start = 1'b1;
        end
        6: begin
          a_ready = 1'b0;
          a_start = 1'b0;
          n_checks++;
          if ({a_busy, a_valid, a_pcnt} !== {1'b1, 1'b0, 17'd1}) begin
            n_fails++;
            $display("FAIL busy_start_cnt: busy=%b valid=%b cnt=%0d expected 1 0 1", a_busy, a_valid, a_pcnt);
          end
        end
        10: begin
          n_checks++;
          if ({a_valid, a_ri, a_rj, a_pcnt} !== {1'b1, 9'd0, 9'd2, 17'd1}) begin
            n_fails++;
            $display("FAIL busy_start_p1: valid=%b i=%0d j=%0d cnt=%0d expected 1 0 2 1", a_valid, a_ri, a_rj, a_pcnt);
          end
        end
        default: ;
      endcase
    end
    // Still in HOLD with ready low. Reset is asserted mid-cycle.
    #2;
    Srst = 1'b1;
    #1;
    n_checks++;
    if ({a_busy, a_done, a_en, a_valid} !== 4'b0000) begin
      n_fails++;
      $display("FAIL async_flags: busy/done/en/valid got %b expected 0000", {a_busy, a_done, a_en, a_valid});
    end
    n_checks++;
    if ({a_data, a_ri, a_rj, a_pcnt, a_e1, a_e2} !== {43'd0, 8'd1, 8'd1}) begin
      n_fails++;
      $display("FAIL async_values: data=%0d i=%0d j=%0d cnt=%0d e=%0d/%0d expected 0 0 0 0 1/1",
               a_data, a_ri, a_rj, a_pcnt, a_e1, a_e2);
    end
    @(negedge clk_0);
    Srst = 1'b0;
    @(negedge clk_0);
    n_checks++;
    if ({a_busy, a_valid} !== 2'b00) begin
      n_fails++;
      $display("FAIL async_release: busy/valid got %b expected 00", {a_busy, a_valid});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_small_grid();
    test_backpressure();
    test_clamp();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
